// File: rtl/rdid_controller.sv
`default_nettype none
// ============================================================================
// Module   : rdid_controller
// Purpose  : Runs one SPI-flash RDID (0x9F) transaction in mode 0 on each
//            rising edge of the debounced start level. It returns the 24-bit
//            JEDEC ID together with a one-cycle valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module rdid_controller #(
  parameter int         CLK_DIV = 2,      // SCLK half-period in clk cycles (1..255)
  parameter logic [7:0] CMD     = 8'h9F   // command byte, shifted MSB first
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [23:0] id_data,
  output logic        id_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
  // Toggle index (0-based, before increment) of the 9th SCLK rise.
  // The first 8 rises belong to the command byte.
  localparam logic [5:0] c_first_cap = 6'd16;
  localparam logic [5:0] c_last_tog  = 6'd63;

  state_t      r_state;
  logic        r_start_q;   // previous start level, for rising-edge detection
  logic        r_req;       // registered request; the FSM acts on it one cycle later
  logic [7:0]  r_div;       // clk cycles elapsed in the current half-period / wait
  logic [5:0]  r_tog;       // SCLK toggles already issued in this transaction
  logic [7:0]  r_cmd;       // command bits not yet presented on MOSI
  logic [23:0] r_cap;       // ID bits shifted in from MISO

  logic w_req;
  logic w_div_done;

  assign w_req      = start & ~r_start_q;
  assign w_div_done = (r_div == c_div_last);

  // Transaction sequencer: edge detect, SCLK divider, shift registers and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b1;
      r_req     <= 1'b0;
      r_div     <= 8'd0;
      r_tog     <= 6'd0;
      r_cmd     <= 8'd0;
      r_cap     <= 24'd0;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      id_data   <= 24'd0;
      id_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_start_q <= start;
      r_req     <= w_req;
      id_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_req) begin
            r_state  <= S_SHIFT;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            spi_mosi <= CMD[7];
            r_cmd    <= {CMD[6:0], 1'b0};
            r_div    <= 8'd0;
            r_tog    <= 6'd0;
          end
        end
        S_SHIFT: begin
          if (w_div_done) begin
            r_div    <= 8'd0;
            spi_sclk <= ~spi_sclk;
            r_tog    <= r_tog + 6'd1;
            if (!spi_sclk) begin
              // Rising SCLK: flash data is stable, so capture once past the command.
              if (r_tog >= c_first_cap) begin
                r_cap <= {r_cap[22:0], spi_miso};
              end
            end else begin
              // Falling SCLK: present the next command bit (zeros once exhausted).
              spi_mosi <= r_cmd[7];
              r_cmd    <= {r_cmd[6:0], 1'b0};
              if (r_tog == c_last_tog) begin
                r_state <= S_HOLD;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_HOLD: begin
          if (w_div_done) begin
            r_div    <= 8'd0;
            spi_cs_n <= 1'b1;
            id_data  <= r_cap;
            id_valid <= 1'b1;
            r_state  <= S_GAP;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_GAP: begin
          if (w_div_done) begin
            r_div   <= 8'd0;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rdid_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdid_controller
// Purpose  : Bench for rdid_controller. It runs two instances (CLK_DIV=2 and
//            CLK_DIV=1) from a shared start/reset, each with a flash model and
//            a timing model built from the transaction edge schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdid_controller;

  localparam logic [7:0] CMD_BYTE = 8'h9F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b1;
  logic        cs_n [2];
  logic        sclk [2];
  logic        mosi [2];
  logic        val  [2];
  logic        bsy  [2];
  logic [23:0] idd  [2];
  logic [23:0] fid  [2];          // ID each flash model returns

  int checks = 0;
  int errors = 0;
  int cyc    = 0;                 // index of the most recent rising clk edge

  int          vcount [2] = '{0, 0};   // id_valid pulses seen
  int          vlast  [2] = '{0, 0};   // edge index of the latest pulse
  int          lrises [2] = '{0, 0};   // SCLK rises in the last CS-low window
  int          gap    [2] = '{0, 0};   // cycles CS stayed high before the last CS fall
  int          hi_t   [2] = '{0, 0};
  logic [7:0]  mbyte  [2];             // MOSI bits seen on the first 8 SCLK rises

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int D = (gi == 0) ? 2 : 1;

    logic w_miso;
    int   rises = 0;

    rdid_controller #(.CLK_DIV(D), .CMD(CMD_BYTE)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .spi_cs_n (cs_n[gi]),
      .spi_sclk (sclk[gi]),
      .spi_mosi (mosi[gi]),
      .spi_miso (w_miso),
      .id_data  (idd[gi]),
      .id_valid (val[gi]),
      .busy     (bsy[gi])
    );

    // Flash: after 8 command clocks, drive ID bits MSB first for the next rise.
    assign w_miso = (rises >= 8 && rises < 32) ? fid[gi][5'(31 - rises)] : 1'b0;

    always @(negedge cs_n[gi]) begin
      rises   = 0;
      gap[gi] = cyc - hi_t[gi];
    end
    always @(posedge cs_n[gi]) begin
      lrises[gi] = rises;
      hi_t[gi]   = cyc;
    end
    always @(posedge sclk[gi]) begin
      if (cs_n[gi] === 1'b0) begin
        if (rises < 8) mbyte[gi] = {mbyte[gi][6:0], mosi[gi]};
        rises++;
      end
    end

    // Reference: outputs follow from the edge offset since the accepted request.
    int          mc  = 0;
    int          n0  = 0;
    bit          act = 1'b0;
    bit          prv = 1'b1;
    logic [23:0] mid = '0;
    logic        e_cs = 1'b1, e_sclk = 1'b0, e_mosi = 1'b0, e_busy = 1'b0, e_val = 1'b0;

    always @(posedge clk) begin
      int rel, tog, f;
      mc++;
      if (reset) begin
        prv = 1'b1;
        act = 1'b0;
        mid = '0;
      end else begin
        if (act && mc == n0 + 1 + 65*D) mid = fid[gi];
        if (start && !prv && (!act || mc >= n0 + 1 + 66*D)) begin
          act = 1'b1;
          n0  = mc;
        end
        prv = start;
      end
      e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_val = 1'b0;
      if (act) begin
        rel = mc - n0;
        if (rel >= 1 && rel <= 66*D) e_busy = 1'b1;
        if (rel >= 1 && rel <= 65*D) begin
          e_cs = 1'b0;
          tog  = (rel - 1) / D;
          if (tog > 64) tog = 64;
          e_sclk = tog[0];
          f      = tog / 2;
          e_mosi = (f < 8) ? CMD_BYTE[7 - f] : 1'b0;
        end
        if (rel == 65*D + 1) e_val = 1'b1;
      end
    end

    always @(negedge clk) begin
      if (val[gi] === 1'b1) begin
        vcount[gi]++;
        vlast[gi] = cyc;
      end
      if (mc > 0) begin
        checks++;
        if ({cs_n[gi], sclk[gi], mosi[gi], bsy[gi], val[gi]} !== {e_cs, e_sclk, e_mosi, e_busy, e_val}
            || idd[gi] !== mid) begin
          errors++;
          $display("FAIL model D=%0d cyc %0d: got cs=%b sclk=%b mosi=%b busy=%b valid=%b id=%h want cs=%b sclk=%b mosi=%b busy=%b valid=%b id=%h",
                   D, cyc, cs_n[gi], sclk[gi], mosi[gi], bsy[gi], val[gi], idd[gi],
                   e_cs, e_sclk, e_mosi, e_busy, e_val, mid);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n, n2;
    int v0 [2];
    int lat [2];
    lat = '{131, 66};
    fid[0] = 24'hEF4018;
    fid[1] = 24'h202015;

    // Reset with start held high, then release with start still high.
    step(3);
    reset = 1'b0;
    step(20);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_cs_n[%0d]", i), 32'(cs_n[i]), 32'd1);
      chk($sformatf("rst_sclk[%0d]", i), 32'(sclk[i]), 32'd0);
      chk($sformatf("rst_busy[%0d]", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("rst_id[%0d]", i), 32'(idd[i]), 32'd0);
      chk($sformatf("rst_nvalid[%0d]", i), 32'(vcount[i]), 32'd0);
    end

    // Nominal read.
    start = 1'b0;
    step(5);
    v0 = vcount;
    start = 1'b1;
    n = cyc + 1;
    step(3);
    start = 1'b0;
    step(140);
    chk("nom_id_d2", 32'(idd[0]), 32'h00EF4018);
    chk("nom_id_d1", 32'(idd[1]), 32'h00202015);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("nom_nvalid[%0d]", i), 32'(vcount[i] - v0[i]), 32'd1);
      chk($sformatf("nom_latency[%0d]", i), 32'(vlast[i] - n), 32'(lat[i]));
      chk($sformatf("nom_mosi[%0d]", i), 32'(mbyte[i]), 32'h9F);
      chk($sformatf("nom_rises[%0d]", i), 32'(lrises[i]), 32'd32);
    end

    // Start held high for a long time: a single transaction.
    step(5);
    v0 = vcount;
    start = 1'b1;
    step(5000);
    start = 1'b0;
    step(10);
    for (int i = 0; i < 2; i++)
      chk($sformatf("held_nvalid[%0d]", i), 32'(vcount[i] - v0[i]), 32'd1);

    // Re-press at N+50 while busy: ignored.
    step(5);
    v0 = vcount;
    start = 1'b1;
    n = cyc + 1;
    step(3);
    start = 1'b0;
    step(47);
    start = 1'b1;
    step(10);
    start = 1'b0;
    step(150);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("repress_nvalid[%0d]", i), 32'(vcount[i] - v0[i]), 32'd1);
      chk($sformatf("repress_latency[%0d]", i), 32'(vlast[i] - n), 32'(lat[i]));
    end

    // Back-to-back: second request sampled at N+133.
    step(5);
    v0 = vcount;
    start = 1'b1;
    n = cyc + 1;
    step(3);
    start = 1'b0;
    step(130);
    fid[0] = 24'hC22017;
    fid[1] = 24'hC22017;
    start = 1'b1;
    n2 = cyc + 1;
    chk("b2b_second_edge", 32'(n2 - n), 32'd133);
    step(3);
    start = 1'b0;
    step(140);
    chk("b2b_id_d2", 32'(idd[0]), 32'h00C22017);
    chk("b2b_id_d1", 32'(idd[1]), 32'h00C22017);
    chk("b2b_latency_d2", 32'(vlast[0] - n2), 32'd131);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("b2b_nvalid[%0d]", i), 32'(vcount[i] - v0[i]), 32'd2);
      chk($sformatf("b2b_cs_gap_ge2[%0d]", i), 32'(gap[i] >= 2), 32'd1);
    end

    // Reset asserted at edge N+60.
    fid[0] = 24'hEF4018;
    fid[1] = 24'h202015;
    step(5);
    v0 = vcount;
    start = 1'b1;
    step(3);
    start = 1'b0;
    step(57);
    reset = 1'b1;
    step(1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midrst_cs_n[%0d]", i), 32'(cs_n[i]), 32'd1);
      chk($sformatf("midrst_sclk[%0d]", i), 32'(sclk[i]), 32'd0);
      chk($sformatf("midrst_id[%0d]", i), 32'(idd[i]), 32'd0);
      chk($sformatf("midrst_busy[%0d]", i), 32'(bsy[i]), 32'd0);
    end
    reset = 1'b0;
    step(200);
    for (int i = 0; i < 2; i++)
      chk($sformatf("midrst_nvalid[%0d]", i), 32'(vcount[i] - v0[i]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rdid_controller.md
# rdid_controller

Sequences a single SPI flash Read Identification (RDID, 0x9F) transaction each time the debounced push-button input rises. It sits between the `debounce` block (whose `data_debounced` drives `start`) and the board's SPI flash pins. It drives the SPI mode-0 bus and returns the 24-bit JEDEC ID (manufacturer, memory type, capacity) with a one-cycle valid strobe.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; legal range 1..255.
- `CMD`, default 8'h9F: command byte shifted out MSB first.
- `clk`, input, 1: system clock, 50 MHz; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: debounced request level; a rising edge requests a transaction.
- `spi_cs_n`, output, 1: flash chip select, active low.
- `spi_sclk`, output, 1: SPI clock, idle low.
- `spi_mosi`, output, 1: command data to flash.
- `spi_miso`, input, 1: ID data from flash.
- `id_data`, output, 24: last captured ID; `[23:16]` is the manufacturer byte.
- `id_valid`, output, 1: one-cycle pulse when `id_data` updates.
- `busy`, output, 1: high from the transaction start through the end of the CS gap.

## Operation
- Reset values:
  - `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `id_data`=0, `id_valid`=0, `busy`=0.
  - State is IDLE; the internal `start_q` register is 1, so a `start` already high at reset release does not trigger.
- Edge detect: a request is recognised when `start`=1 and `start_q`=0. `start_q` registers `start` every cycle.
- States:
  - IDLE: on request, go to SHIFT with `spi_cs_n`=0, `busy`=1, `spi_mosi`=`CMD[7]`; clear the bit counter and divider.
  - SHIFT: `spi_sclk` toggles every `CLK_DIV` cycles, 64 toggles total (32 SCLK periods).
    - On each rising toggle, sample `spi_miso`. Bits 9..32 shift MSB-first into the 24-bit capture register; bits 1..8 are discarded.
    - On each falling toggle, `spi_mosi` presents the next `CMD` bit. After the 8th falling toggle `spi_mosi`=0.
    - After toggle 64 (SCLK low), go to HOLD.
  - HOLD: wait `CLK_DIV` cycles with `spi_cs_n`=0. Then set `spi_cs_n`=1, load the capture register into `id_data`, pulse `id_valid`, and go to GAP.
  - GAP: wait `CLK_DIV` cycles (minimum CS-high time), then go to IDLE with `busy`=0.
- Requests arriving in any state other than IDLE are ignored and are not queued.
- Reset mid-transaction: at the next edge all outputs return to reset values; no `id_valid` pulse; `id_data`=0.
- `id_data` holds its value between transactions and is unchanged by an ignored request.

## Timing
- Let `D`=`CLK_DIV`, and let edge N be the edge at which the request is sampled (`start`=1, `start_q`=0).
- Edge N+1: `spi_cs_n` falls, `busy` rises, `spi_mosi`=`CMD[7]`.
- SCLK toggle k (k=1..64) occurs at edge N+1+k·D. Odd k is a rising toggle, even k is a falling toggle.
- MISO sampling: at the odd toggles k=17..63, on the same edge as the SCLK rise.
- Edge N+1+65·D: `spi_cs_n`=1, `id_valid`=1 for one cycle, `id_data` valid.
- Edge N+1+66·D: `busy`=0. A new request can be sampled from this edge onward.
- With D=2: CS low at N+1, `id_valid` at N+131, `busy` low at N+133.
- Mode 0 timing is met: MOSI is stable D cycles before each SCLK rise.

## Test plan
- Reset check: hold `reset` 3 cycles with `start`=1, then release with `start` kept high. Required: all outputs at reset values and no transaction starts.
- Nominal read: D=2, flash model returns 0xEF4018 after the command. Pulse `start` 0→1. Required:
  - MOSI bits 1,0,0,1,1,1,1,1 on the first 8 SCLK rises;
  - `id_data`=0xEF4018 and a single `id_valid` at N+131;
  - exactly 32 SCLK rising edges while `spi_cs_n`=0.
- Held and re-pressed start: hold `start` high 5000 cycles, then drop it. Required: one transaction only. Raise `start` again at N+50 while busy: ignored, so `id_valid` pulses once only.
- Back-to-back: request again at N+133 with the model returning 0xC22017. Required: second `id_valid`, `id_data`=0xC22017, and `spi_cs_n` high for ≥2 cycles between transactions.
- Reset mid-operation: assert `reset` at N+60. Required: next edge `spi_cs_n`=1, `spi_sclk`=0, `id_data`=0, `busy`=0; no `id_valid`.
- Divider sweep: D=1, model returns 0x202015. Required: `id_valid` at N+66, `id_data`=0x202015, and SCLK period of 2 cycles.
